// File: rtl/adder_operand_sequencer.sv
// Purpose: button-paced front end that captures A, then B and mode, feeds the adder, then latches its result.
// Latency: res_valid rises one cycle after the edge that captures B; the result is held until the next press.
// Backpressure: none; the user's presses pace the flow, and a press seen during the execute cycle is dropped.
module adder_operand_sequencer #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] sw_data,
    input  logic             sw_mode,
    input  logic             btn_next,
    output logic [WIDTH-1:0] a_out,
    output logic [WIDTH-1:0] b_out,
    output logic             m_out,
    input  logic [WIDTH-1:0] sum_in,
    input  logic             c_in,
    input  logic             v_in,
    output logic [WIDTH-1:0] res_sum,
    output logic             res_c,
    output logic             res_v,
    output logic             res_valid,
    output logic [1:0]       state_out,
    output logic [CNT_W-1:0] op_count
);

    typedef enum logic [1:0] {
        S_A    = 2'd0,
        S_B    = 2'd1,
        S_EXEC = 2'd2,
        S_HOLD = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic             btn_prev_q;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic             m_q, m_d;
    logic [WIDTH-1:0] res_sum_q, res_sum_d;
    logic             res_c_q, res_c_d;
    logic             res_v_q, res_v_d;
    logic             res_valid_q, res_valid_d;
    logic [CNT_W-1:0] op_count_q, op_count_d;
    logic             press;

    // Rising edge of the level button; a held button gives a single press.
    assign press = btn_next & ~btn_prev_q;

    // Next-state and register-update logic; every register holds unless its state says otherwise.
    always_comb begin
        state_d     = state_q;
        a_d         = a_q;
        b_d         = b_q;
        m_d         = m_q;
        res_sum_d   = res_sum_q;
        res_c_d     = res_c_q;
        res_v_d     = res_v_q;
        res_valid_d = res_valid_q;
        op_count_d  = op_count_q;
        case (state_q)
            S_A: begin
                if (press) begin
                    a_d     = sw_data;
                    state_d = S_B;
                end
            end
            S_B: begin
                // Mode is taken together with B so the operands and mode change at one edge.
                if (press) begin
                    b_d     = sw_data;
                    m_d     = sw_mode;
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                // Operands have been stable for a full cycle, so the adder output has settled.
                res_sum_d   = sum_in;
                res_c_d     = c_in;
                res_v_d     = v_in;
                res_valid_d = 1'b1;
                op_count_d  = op_count_q + CNT_W'(1);
                state_d     = S_HOLD;
            end
            S_HOLD: begin
                if (press) begin
                    res_valid_d = 1'b0;
                    state_d     = S_A;
                end
            end
            default: state_d = S_A;
        endcase
    end

    // State and datapath registers with synchronous reset; btn_prev resets high to mask a held button.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_A;
            btn_prev_q  <= 1'b1;
            a_q         <= '0;
            b_q         <= '0;
            m_q         <= 1'b0;
            res_sum_q   <= '0;
            res_c_q     <= 1'b0;
            res_v_q     <= 1'b0;
            res_valid_q <= 1'b0;
            op_count_q  <= '0;
        end else begin
            state_q     <= state_d;
            btn_prev_q  <= btn_next;
            a_q         <= a_d;
            b_q         <= b_d;
            m_q         <= m_d;
            res_sum_q   <= res_sum_d;
            res_c_q     <= res_c_d;
            res_v_q     <= res_v_d;
            res_valid_q <= res_valid_d;
            op_count_q  <= op_count_d;
        end
    end

    assign a_out     = a_q;
    assign b_out     = b_q;
    assign m_out     = m_q;
    assign res_sum   = res_sum_q;
    assign res_c     = res_c_q;
    assign res_v     = res_v_q;
    assign res_valid = res_valid_q;
    assign state_out = state_q;
    assign op_count  = op_count_q;

endmodule

// File: tb/tb_adder_operand_sequencer.sv
// Purpose: scoreboard bench for adder_operand_sequencer with a behavioural 4-bit add/sub adder attached.
// Latency: expected results are queued when B is pressed and popped when res_valid rises.
// Backpressure: none; stimulus is paced by fixed cycle steps.
module tb_adder_operand_sequencer;

    logic       clk;
    logic       rst;
    logic [3:0] sw_data;
    logic       sw_mode;
    logic       btn_next;
    logic [3:0] a_out, b_out;
    logic       m_out;
    logic [3:0] sum_in;
    logic       c_in, v_in;
    logic [3:0] res_sum;
    logic       res_c, res_v, res_valid;
    logic [1:0] state_out;
    logic [7:0] op_count;

    adder_operand_sequencer #(.WIDTH(4), .CNT_W(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .sw_data   (sw_data),
        .sw_mode   (sw_mode),
        .btn_next  (btn_next),
        .a_out     (a_out),
        .b_out     (b_out),
        .m_out     (m_out),
        .sum_in    (sum_in),
        .c_in      (c_in),
        .v_in      (v_in),
        .res_sum   (res_sum),
        .res_c     (res_c),
        .res_v     (res_v),
        .res_valid (res_valid),
        .state_out (state_out),
        .op_count  (op_count)
    );

    // Behavioural adder: subtract is A + ~B + 1, overflow from operand and sum sign bits.
    logic [3:0] bx;
    logic [4:0] full;
    assign bx     = b_out ^ {4{m_out}};
    assign full   = {1'b0, a_out} + {1'b0, bx} + {4'b0, m_out};
    assign sum_in = full[3:0];
    assign c_in   = full[4];
    assign v_in   = (a_out[3] == bx[3]) && (full[3] != a_out[3]);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] sum;
        logic       c;
        logic       v;
        logic [7:0] cnt;
    } exp_t;

    exp_t exp_q[$];
    int   tests  = 0;
    int   failed = 0;
    int   ops_done = 0;
    logic prev_valid = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic press();
        btn_next = 1'b1;
        step();
        btn_next = 1'b0;
        step();
    endtask

    task automatic push_exp(input logic [3:0] s, input logic c, input logic v);
        exp_t e;
        ops_done++;
        e.sum = s;
        e.c   = c;
        e.v   = v;
        e.cnt = 8'(ops_done);
        exp_q.push_back(e);
    endtask

    // Full operation from S_A back to S_A, expected result queued before B is captured.
    task automatic do_op(input logic [3:0] a, input logic [3:0] b, input logic m,
                         input logic [3:0] es, input logic ec, input logic ev);
        sw_data = a;
        press();
        sw_data = b;
        sw_mode = m;
        push_exp(es, ec, ev);
        press();
        press();
    endtask

    // Monitor: on each rising edge of res_valid compare against the oldest queued result.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (res_valid && !prev_valid) begin
                if (exp_q.size() == 0) begin
                    tests++;
                    failed++;
                    $display("FAIL unexpected_result: got sum %0d with no result expected", res_sum);
                end else begin
                    e = exp_q.pop_front();
                    chk("res_sum", 32'(res_sum), 32'(e.sum));
                    chk("res_c", 32'(res_c), 32'(e.c));
                    chk("res_v", 32'(res_v), 32'(e.v));
                    chk("op_count", 32'(op_count), 32'(e.cnt));
                    chk("state_hold", 32'(state_out), 32'd3);
                end
            end
            prev_valid = res_valid;
        end
    end

    initial begin
        rst      = 1'b1;
        btn_next = 1'b1;
        sw_data  = 4'd0;
        sw_mode  = 1'b0;
        step();
        step();
        chk("rst_state", 32'(state_out), 32'd0);
        chk("rst_a", 32'(a_out), 32'd0);
        chk("rst_b", 32'(b_out), 32'd0);
        chk("rst_m", 32'(m_out), 32'd0);
        chk("rst_res", 32'({res_sum, res_c, res_v, res_valid}), 32'd0);
        chk("rst_count", 32'(op_count), 32'd0);

        // Button still held after reset release must not count as a press.
        rst = 1'b0;
        step();
        step();
        chk("held_through_rst", 32'(state_out), 32'd0);
        btn_next = 1'b0;
        step();
        sw_data = 4'd5;
        press();
        chk("first_press_state", 32'(state_out), 32'd1);
        chk("first_press_a", 32'(a_out), 32'd5);

        // Capture B, then reset during S_EXEC: nothing may be latched.
        sw_data  = 4'd3;
        btn_next = 1'b1;
        step();
        chk("in_exec", 32'(state_out), 32'd2);
        rst      = 1'b1;
        btn_next = 1'b0;
        step();
        rst = 1'b0;
        chk("exec_rst_state", 32'(state_out), 32'd0);
        chk("exec_rst_valid", 32'(res_valid), 32'd0);
        chk("exec_rst_sum", 32'(res_sum), 32'd0);
        chk("exec_rst_count", 32'(op_count), 32'd0);
        step();

        // 5 + 3: signed overflow, no carry.
        do_op(4'd5, 4'd3, 1'b0, 4'd8, 1'b0, 1'b1);
        chk("add_a", 32'(a_out), 32'd5);
        chk("add_b", 32'(b_out), 32'd3);
        chk("add_m", 32'(m_out), 32'd0);
        chk("held_in_sa", 32'(res_sum), 32'd8);
        chk("valid_cleared", 32'(res_valid), 32'd0);

        // 3 - 5: mode switched on while in S_A must not reach m_out until B.
        sw_mode = 1'b1;
        sw_data = 4'd3;
        press();
        chk("mode_not_with_a", 32'(m_out), 32'd0);
        chk("held_in_sb", 32'(res_sum), 32'd8);
        sw_data = 4'd5;
        push_exp(4'd14, 1'b0, 1'b0);
        press();
        chk("sub_m", 32'(m_out), 32'd1);
        press();

        // 15 + 1: carry out, no overflow.
        do_op(4'd15, 4'd1, 1'b0, 4'd0, 1'b1, 1'b0);

        // Button held 10 cycles in S_A: exactly one step, B untouched.
        sw_data  = 4'd7;
        btn_next = 1'b1;
        for (int i = 0; i < 10; i++) step();
        chk("held_state", 32'(state_out), 32'd1);
        chk("held_a", 32'(a_out), 32'd7);
        chk("held_b", 32'(b_out), 32'd1);
        btn_next = 1'b0;
        sw_data  = 4'd2;
        sw_mode  = 1'b0;
        step();
        chk("release_state", 32'(state_out), 32'd1);
        push_exp(4'd9, 1'b0, 1'b1);
        press();
        chk("second_press_b", 32'(b_out), 32'd2);
        press();

        // Run to 256 completed operations; the counter wraps to zero.
        while (ops_done < 256) do_op(4'd0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0);
        step();
        chk("count_wrap", 32'(op_count), 32'd0);
        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
